load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store sequencer between the execute stage and `Data_Memory`. It accepts one memory request at a time: LW, LH, LHU, LB, LBU, SW, SH or SB. Sub-word loads are byte-lane extracted and sign- or zero-extended. Sub-word stores are done as a read-modify-write, because `Data_Memory` only writes full 32-bit words. The unit flags misaligned and out-of-range accesses instead of issuing them.

## Interface
- MEM_BYTES, 128: data memory size in bytes; valid word indices are 0 .. MEM_BYTES/4-1.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- req_i  in  1  request valid; accepted when req_i && ready_o.
- op_i  in  3  operation: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data; the low byte/half is used for SB/SH.
- ready_o  out  1  unit idle, can accept.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  32  load result, registered; held until the next load completes.
- err_o  out  1  with done_o: request rejected (misaligned or out of range).
- mem_addr_o  out  32  word-aligned address to `Data_Memory` (addr[1:0]=0).
- mem_wdata_o  out  32  full write word.
- mem_read_o  out  1  MemRead.
- mem_write_o  out  1  MemWrite.
- mem_rdata_i  in  32  combinational read data from `Data_Memory`.

## Operation
- Byte order is little-endian: byte k of a word is bits [8k+7:8k]. A half at addr[1] uses bits [16·addr[1]+15 : 16·addr[1]].
- Alignment rules:
  - Word access: addr[1:0]=0.
  - Half access: addr[0]=0.
  - Byte access: no constraint.
- Range rule: addr[31:2] < MEM_BYTES/4.
- States:
  - IDLE: ready_o=1. On accept, latch op, addr and wdata.
    - If the access is misaligned or out of range, go to ERR.
    - Otherwise go to ACCESS.
  - ACCESS: mem_addr_o is the word address.
    - Loads: mem_read_o=1; register the extracted and extended value into rdata_o; go to DONE.
    - SW: mem_write_o=1 with mem_wdata_o=wdata; go to DONE.
    - SH/SB: mem_read_o=1; capture mem_rdata_i into the merge register with the target lane replaced; go to WRITE.
  - WRITE: mem_write_o=1, mem_wdata_o=merge register; go to DONE.
  - DONE: done_o=1; go to IDLE.
  - ERR: done_o=1, err_o=1; no memory strobe; rdata_o unchanged; go to IDLE.
- Sign extension: LH and LB replicate the top bit of the lane. LHU and LBU zero-fill.
- mem_read_o and mem_write_o are decoded from the state and are never both high.
- When no write is in progress, mem_wdata_o=0. When the state is IDLE, DONE or ERR, mem_addr_o=0.

## Timing
- Accept at edge 0.
- Latency from accept edge to done_o:
  - Loads and SW: done_o high in the cycle after ACCESS, i.e. 2 cycles.
  - SH/SB: 3 cycles.
  - Error: 1 cycle.
- ready_o is low from the accept edge until the edge that leaves DONE/ERR. The next request can be accepted in the cycle after done_o.
- req_i while busy is ignored, not queued. The requester holds req_i, op_i, addr_i and wdata_i until ready_o.
- The memory write commits at the rising edge that ends ACCESS (SW) or WRITE (SH/SB).
- The RMW is atomic from the unit's view: no other request can interleave.
- Reset values: state=IDLE, ready_o=1, done_o=0, err_o=0, rdata_o=0, mem_* strobes/addr/wdata=0.
- Reset asserted mid-operation:
  - Strobes drop immediately (asynchronous reset).
  - A write whose edge has not yet occurred is abandoned, leaving memory unchanged.
  - No done_o is issued for the aborted request.

## Structure
- Shared package `lsu_pkg` holds:
  - Op encodings LSU_LW..LSU_SB.
  - State encoding (IDLE, ACCESS, WRITE, DONE, ERR).
  - Helper predicates is_load, is_half, is_byte, is_signed.
- One combinational sub-module `lsu_lane_align`:
  - Inputs: op, addr[1:0], mem word, store data.
  - Outputs: extended load value and merged store word.
  - The FSM and all registers stay in `load_store_unit`.

## Test plan
- LW addr 0x10 with word 0x10 preloaded as 0x8899AABB -> rdata_o=0x8899AABB, done_o 2 cycles after accept, err_o=0.
- Loads with word 0x10 = 0x8899AABB:
  - LB 0x11 -> 0xFFFFFFAA.
  - LBU 0x11 -> 0x000000AA.
  - LH 0x12 -> 0xFFFF8899.
  - LHU 0x10 -> 0x0000AABB.
- SB addr 0x12 wdata 0x12345655 -> word 0x10 becomes 0x8855AABB.
  - Exactly one mem_read_o cycle, then one mem_write_o cycle.
  - done_o 3 cycles after accept.
- Error cases, each giving err_o=1 with done_o 1 cycle after accept and no mem strobe:
  - LH 0x13.
  - SW 0x02.
  - LW 0x80 (out of range with MEM_BYTES=128).
- SH addr 0x10 with rst_i pulsed low during WRITE:
  - All outputs 0 immediately; word 0x10 unchanged.
  - ready_o=1 after release; no done_o.
- SW 0x20 data 0xDEADBEEF with req_i held high, then LW 0x20 issued immediately:
  - Second request is not accepted before ready_o.
  - LW returns 0xDEADBEEF.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op and state encodings plus
// small predicates on the op code.
package lsu_pkg;

   typedef enum logic [2:0] {
      LSU_LW  = 3'd0,
      LSU_LH  = 3'd1,
      LSU_LHU = 3'd2,
      LSU_LB  = 3'd3,
      LSU_LBU = 3'd4,
      LSU_SW  = 3'd5,
      LSU_SH  = 3'd6,
      LSU_SB  = 3'd7
   } lsu_op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACCESS = 3'd1,
      ST_WRITE  = 3'd2,
      ST_DONE   = 3'd3,
      ST_ERR    = 3'd4
   } lsu_state_e;

   function automatic logic is_load(lsu_op_e op);
      return (op == LSU_LW) || (op == LSU_LH) || (op == LSU_LHU) ||
             (op == LSU_LB) || (op == LSU_LBU);
   endfunction

   function automatic logic is_half(lsu_op_e op);
      return (op == LSU_LH) || (op == LSU_LHU) || (op == LSU_SH);
   endfunction

   function automatic logic is_byte(lsu_op_e op);
      return (op == LSU_LB) || (op == LSU_LBU) || (op == LSU_SB);
   endfunction

   function automatic logic is_signed(lsu_op_e op);
      return (op == LSU_LH) || (op == LSU_LB);
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response channel between the execute stage (master) and the
// load/store unit (slave).
interface load_store_unit_if;
   logic        req;
   logic [2:0]  op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ready;
   logic        done;
   logic [31:0] rdata;
   logic        err;

   modport master (output req, op, addr, wdata,
                   input  ready, done, rdata, err);

   modport slave  (input  req, op, addr, wdata,
                   output ready, done, rdata, err);
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts and extends load data from a memory word, and
// builds the merged word for sub-word stores. Purely combinational.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  lsu_op_e     op,
   input  logic [1:0]  byte_sel,
   input  logic [31:0] mem_word,
   input  logic [31:0] store_data,
   output logic [31:0] load_value,
   output logic [31:0] merge_word
);

   logic [7:0]  lane [4];
   logic [7:0]  byte_val;
   logic [15:0] half_val;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic       take_store;
         logic [7:0] store_byte;

         assign lane[gi] = mem_word[8*gi +: 8];

         // A lane takes store data if the access covers it; other lanes keep memory contents.
         assign take_store = (op == LSU_SW) ||
                             (is_half(op) && (byte_sel[1] == ((gi / 2) != 0))) ||
                             (is_byte(op) && (byte_sel == 2'(gi)));
         assign store_byte = is_byte(op) ? store_data[7:0] :
                             is_half(op) ? store_data[8*(gi%2) +: 8] :
                                           store_data[8*gi +: 8];
         assign merge_word[8*gi +: 8] = take_store ? store_byte : lane[gi];
      end
   endgenerate

   // Select the addressed byte/half and sign- or zero-extend it.
   always_comb begin
      byte_val   = lane[byte_sel];
      half_val   = byte_sel[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};
      load_value = mem_word;
      if (is_byte(op))
         load_value = {{24{is_signed(op) & byte_val[7]}}, byte_val};
      else if (is_half(op))
         load_value = {{16{is_signed(op) & half_val[15]}}, half_val};
   end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store sequencer in front of a word-only data memory.
// Sub-word stores are read-modify-write; bad requests are answered with err.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 128
)
(
   input  logic               clk_i,
   input  logic               rst_i,
   load_store_unit_if.slave   bus,
   output logic [31:0]        mem_addr_o,
   output logic [31:0]        mem_wdata_o,
   output logic               mem_read_o,
   output logic               mem_write_o,
   input  logic [31:0]        mem_rdata_i
);

   localparam int unsigned WORD_COUNT = MEM_BYTES / 4;

   lsu_state_e  state_reg, state_next;
   lsu_op_e     op_reg;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   logic [31:0] merge_reg;
   logic [31:0] rdata_reg;

   lsu_op_e     req_op;
   logic        req_bad;
   logic        accept;
   logic [31:0] load_value;
   logic [31:0] merge_word;

   assign req_op  = lsu_op_e'(bus.op);
   assign req_bad = ((req_op == LSU_LW || req_op == LSU_SW) && (bus.addr[1:0] != 2'b00)) ||
                    (is_half(req_op) && bus.addr[0]) ||
                    (bus.addr[31:2] >= 30'(WORD_COUNT));
   assign accept  = (state_reg == ST_IDLE) && bus.req;
   assign bus.rdata = rdata_reg;

   lsu_lane_align u_lane_align (
      .op         (op_reg),
      .byte_sel   (addr_reg[1:0]),
      .mem_word   (mem_rdata_i),
      .store_data (wdata_reg),
      .load_value (load_value),
      .merge_word (merge_word)
   );

   // State register; reset returns to IDLE immediately, dropping all strobes.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   // Next state and all state-decoded outputs.
   always_comb begin
      state_next  = state_reg;
      bus.ready   = 1'b0;
      bus.done    = 1'b0;
      bus.err     = 1'b0;
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      case (state_reg)
         ST_IDLE: begin
            bus.ready = 1'b1;
            if (accept) state_next = req_bad ? ST_ERR : ST_ACCESS;
         end
         ST_ACCESS: begin
            mem_addr_o = {addr_reg[31:2], 2'b00};
            if (op_reg == LSU_SW) begin
               mem_write_o = 1'b1;
               mem_wdata_o = wdata_reg;
               state_next  = ST_DONE;
            end else begin
               mem_read_o = 1'b1;
               state_next = is_load(op_reg) ? ST_DONE : ST_WRITE;
            end
         end
         ST_WRITE: begin
            mem_addr_o  = {addr_reg[31:2], 2'b00};
            mem_write_o = 1'b1;
            mem_wdata_o = merge_reg;
            state_next  = ST_DONE;
         end
         ST_DONE: begin
            bus.done   = 1'b1;
            state_next = ST_IDLE;
         end
         ST_ERR: begin
            bus.done   = 1'b1;
            bus.err    = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Request capture, load result and read-modify-write merge registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         op_reg    <= LSU_LW;
         addr_reg  <= '0;
         wdata_reg <= '0;
         merge_reg <= '0;
         rdata_reg <= '0;
      end else begin
         if (accept) begin
            op_reg    <= req_op;
            addr_reg  <= bus.addr;
            wdata_reg <= bus.wdata;
         end
         if (state_reg == ST_ACCESS) begin
            if (is_load(op_reg))
               rdata_reg <= load_value;
            else if (op_reg != LSU_SW)
               merge_reg <= merge_word;
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand-written
// reset/back-to-back sequences, then random traffic against a byte-array model.
module tb_load_store_unit;
   import lsu_pkg::*;

   localparam int MEM_BYTES = 128;
   localparam int WORDS     = MEM_BYTES / 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   load_store_unit_if bus_if();

   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_read, mem_write;

   load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
      .clk_i       (clk),
      .rst_i       (rst_n),
      .bus         (bus_if),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_read_o  (mem_read),
      .mem_write_o (mem_write),
      .mem_rdata_i (mem_rdata)
   );

   // Data memory fixture: combinational read, write at rising edge.
   logic [31:0] dmem [WORDS];
   logic        tb_wr = 1'b0;
   logic [4:0]  tb_idx = '0;
   logic [31:0] tb_val = '0;
   assign mem_rdata = dmem[mem_addr[6:2]];
   always @(posedge clk) begin
      if (mem_write)  dmem[mem_addr[6:2]] <= mem_wdata;
      else if (tb_wr) dmem[tb_idx] <= tb_val;
   end

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: byte-addressed memory and last load result.
   logic [7:0]  ref_mem [MEM_BYTES];
   logic [31:0] ref_rdata = '0;

   function automatic logic [31:0] ref_word(int idx);
      return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
   endfunction

   task automatic ref_apply(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic err, output int lat, output int nrd, output int nwr);
      longint a, v;
      int     size;
      a    = longint'(addr);
      size = (op == 3'd0 || op == 3'd5) ? 4 : (op == 3'd1 || op == 3'd2 || op == 3'd6) ? 2 : 1;
      err  = ((a % size) != 0) || (a >= MEM_BYTES);
      lat = 1; nrd = 0; nwr = 0;
      if (!err) begin
         if (op < 3'd5) begin
            v = 0;
            for (int k = 0; k < size; k++) v = v + (longint'(ref_mem[a+k]) << (8*k));
            if (op == 3'd1 && v >= 32768) v = v - 65536;
            if (op == 3'd3 && v >= 128)   v = v - 256;
            ref_rdata = 32'(v);
            lat = 2; nrd = 1;
         end else begin
            for (int k = 0; k < size; k++) ref_mem[a+k] = wdata[8*k +: 8];
            lat = (size == 4) ? 2 : 3;
            nrd = (size == 4) ? 0 : 1;
            nwr = 1;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
      end
   endtask

   task automatic poke(input int idx, input logic [31:0] val);
      @(negedge clk);
      tb_wr = 1'b1; tb_idx = 5'(idx); tb_val = val;
      @(negedge clk);
      tb_wr = 1'b0;
      for (int k = 0; k < 4; k++) ref_mem[4*idx+k] = val[8*k +: 8];
   endtask

   // Issue one request and observe it until done_o (bounded).
   task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output int nrd, output int nwr, output logic err,
                         output logic [31:0] rd, output logic addr_ok, output logic [31:0] wr_word);
      logic got_done;
      @(negedge clk);
      check("ready_before_req", 32'(bus_if.ready), 32'd1);
      bus_if.req = 1'b1; bus_if.op = op; bus_if.addr = addr; bus_if.wdata = wdata;
      lat = 0; nrd = 0; nwr = 0; err = 1'b0; rd = '0; addr_ok = 1'b1; wr_word = '0;
      got_done = 1'b0;
      @(posedge clk);
      while (!got_done && lat < 8) begin
         @(negedge clk);
         lat++;
         bus_if.req = 1'b0;
         nrd += int'(mem_read);
         nwr += int'(mem_write);
         if (mem_write) wr_word = mem_wdata;
         if ((mem_read || mem_write) && (mem_addr != {addr[31:2], 2'b00})) addr_ok = 1'b0;
         if (bus_if.done) begin
            got_done = 1'b1;
            err = bus_if.err;
            rd  = bus_if.rdata;
         end
      end
      if (!got_done) begin
         n_checks++; n_fail++;
         $display("FAIL done_timeout: op=%0d addr=0x%08h no done_o within 8 cycles", op, addr);
      end
   endtask

   // Continuous bus-rule monitor: strobes exclusive, idle bus is quiet.
   always @(negedge clk) begin
      if (rst_n) begin
         n_checks++;
         if (mem_read && mem_write) begin
            n_fail++;
            $display("FAIL strobe_overlap: read=%0b write=%0b required not both 1", mem_read, mem_write);
         end
         if (bus_if.ready) begin
            n_checks++;
            if (mem_read || mem_write || mem_addr != 0 || mem_wdata != 0) begin
               n_fail++;
               $display("FAIL idle_bus: rd=%0b wr=%0b addr=0x%08h wdata=0x%08h required all 0",
                        mem_read, mem_write, mem_addr, mem_wdata);
            end
         end
      end
   end

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_nrd;
      int          exp_nwr;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [10];

   initial begin
      int          lat, nrd, nwr, e_lat, e_nrd, e_nwr;
      logic        err, e_err, addr_ok;
      logic [31:0] rd, wr_word, a, wd;
      logic [2:0]  op;
      int          first_done, second_done, sq_rd, sq_wr, done_cnt;
      logic [31:0] sq_rdata;

      vecs[0] = '{3'(LSU_LW),  32'h10, 32'h0,        1'b0, 2, 1, 0, 32'h8899AABB};
      vecs[1] = '{3'(LSU_LB),  32'h11, 32'h0,        1'b0, 2, 1, 0, 32'hFFFFFFAA};
      vecs[2] = '{3'(LSU_LBU), 32'h11, 32'h0,        1'b0, 2, 1, 0, 32'h000000AA};
      vecs[3] = '{3'(LSU_LH),  32'h12, 32'h0,        1'b0, 2, 1, 0, 32'hFFFF8899};
      vecs[4] = '{3'(LSU_LHU), 32'h10, 32'h0,        1'b0, 2, 1, 0, 32'h0000AABB};
      vecs[5] = '{3'(LSU_SB),  32'h12, 32'h12345655, 1'b0, 3, 1, 1, 32'h0000AABB};
      vecs[6] = '{3'(LSU_LW),  32'h10, 32'h0,        1'b0, 2, 1, 0, 32'h8855AABB};
      vecs[7] = '{3'(LSU_LH),  32'h13, 32'h0,        1'b1, 1, 0, 0, 32'h8855AABB};
      vecs[8] = '{3'(LSU_SW),  32'h02, 32'h11111111, 1'b1, 1, 0, 0, 32'h8855AABB};
      vecs[9] = '{3'(LSU_LW),  32'h80, 32'h0,        1'b1, 1, 0, 0, 32'h8855AABB};

      bus_if.req = 1'b0; bus_if.op = '0; bus_if.addr = '0; bus_if.wdata = '0;

      // Reset state, then preload memory while still in reset.
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(bus_if.ready), 32'd1);
      check("rst_done",  32'(bus_if.done),  32'd0);
      check("rst_err",   32'(bus_if.err),   32'd0);
      check("rst_rdata", bus_if.rdata,      32'd0);
      check("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      for (int i = 0; i < WORDS; i++) poke(i, $urandom);
      poke(4, 32'h8899AABB);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vector table.
      for (int i = 0; i < 10; i++) begin
         ref_apply(vecs[i].op, vecs[i].addr, vecs[i].wdata, e_err, e_lat, e_nrd, e_nwr);
         run_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, lat, nrd, nwr, err, rd, addr_ok, wr_word);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
         check($sformatf("vec%0d_reads", i), 32'(nrd), 32'(vecs[i].exp_nrd));
         check($sformatf("vec%0d_writes", i), 32'(nwr), 32'(vecs[i].exp_nwr));
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("vec%0d_addr", i), 32'(addr_ok), 32'd1);
         $display("vec%0d op=%0d addr=0x%08h lat=%0d err=%0b rdata=0x%08h", i, vecs[i].op, vecs[i].addr, lat, err, rd);
      end
      check("sb_merged_word", dmem[4], 32'h8855AABB);

      // Reset pulsed during the WRITE cycle of an SH: write abandoned, no done.
      @(negedge clk);
      bus_if.req = 1'b1; bus_if.op = 3'(LSU_SH); bus_if.addr = 32'h10; bus_if.wdata = 32'hCAFE1234;
      @(posedge clk);
      @(negedge clk);
      bus_if.req = 1'b0;
      check("rstseq_access_read", 32'(mem_read), 32'd1);
      @(negedge clk);
      check("rstseq_write_strobe", 32'(mem_write), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("rstseq_write_drop", 32'(mem_write), 32'd0);
      check("rstseq_read_drop", 32'(mem_read), 32'd0);
      check("rstseq_addr_zero", mem_addr, 32'd0);
      check("rstseq_wdata_zero", mem_wdata, 32'd0);
      check("rstseq_done_zero", 32'(bus_if.done), 32'd0);
      check("rstseq_rdata_zero", bus_if.rdata, 32'd0);
      ref_rdata = '0;
      @(negedge clk);
      rst_n = 1'b1;
      done_cnt = 0;
      repeat (4) begin
         @(negedge clk);
         done_cnt += int'(bus_if.done);
      end
      check("rstseq_no_done", 32'(done_cnt), 32'd0);
      check("rstseq_ready", 32'(bus_if.ready), 32'd1);
      check("rstseq_mem_unchanged", dmem[4], ref_word(4));
      $display("rstseq SH 0x10 aborted: word=0x%08h", dmem[4]);

      // SW with req held, LW presented right behind it.
      @(negedge clk);
      bus_if.req = 1'b1; bus_if.op = 3'(LSU_SW); bus_if.addr = 32'h20; bus_if.wdata = 32'hDEADBEEF;
      ref_apply(3'(LSU_SW), 32'h20, 32'hDEADBEEF, e_err, e_lat, e_nrd, e_nwr);
      ref_apply(3'(LSU_LW), 32'h20, 32'h0, e_err, e_lat, e_nrd, e_nwr);
      @(posedge clk);
      #1;
      bus_if.op = 3'(LSU_LW); bus_if.wdata = 32'h0;
      first_done = 0; second_done = 0; sq_rd = 0; sq_wr = 0; sq_rdata = '0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         sq_rd += int'(mem_read);
         sq_wr += int'(mem_write);
         if (mem_write) check("b2b_sw_wdata", mem_wdata, 32'hDEADBEEF);
         if (bus_if.done) begin
            if (first_done == 0) first_done = c;
            else if (second_done == 0) begin
               second_done = c;
               sq_rdata = bus_if.rdata;
            end
         end
         if (c == 4) bus_if.req = 1'b0;
      end
      check("b2b_sw_done_cycle", 32'(first_done), 32'd2);
      check("b2b_lw_done_cycle", 32'(second_done), 32'd5);
      check("b2b_reads", 32'(sq_rd), 32'd1);
      check("b2b_writes", 32'(sq_wr), 32'd1);
      check("b2b_lw_rdata", sq_rdata, ref_rdata);
      check("b2b_mem_word", dmem[8], 32'hDEADBEEF);
      $display("b2b SW/LW 0x20: done at %0d and %0d rdata=0x%08h", first_done, second_done, sq_rdata);

      // Random traffic against the reference model.
      for (int t = 0; t < 150; t++) begin
         op = 3'($urandom_range(0, 7));
         a  = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, MEM_BYTES + 7);
         wd = $urandom;
         ref_apply(op, a, wd, e_err, e_lat, e_nrd, e_nwr);
         run_op(op, a, wd, lat, nrd, nwr, err, rd, addr_ok, wr_word);
         check($sformatf("rnd%0d_latency", t), 32'(lat), 32'(e_lat));
         check($sformatf("rnd%0d_err", t), 32'(err), 32'(e_err));
         check($sformatf("rnd%0d_reads", t), 32'(nrd), 32'(e_nrd));
         check($sformatf("rnd%0d_writes", t), 32'(nwr), 32'(e_nwr));
         check($sformatf("rnd%0d_rdata", t), rd, ref_rdata);
         check($sformatf("rnd%0d_addr", t), 32'(addr_ok), 32'd1);
         if (!e_err && e_nwr == 1)
            check($sformatf("rnd%0d_write_word", t), wr_word, ref_word(int'(a[6:2])));
         $display("rnd%0d op=%0d addr=0x%08h wdata=0x%08h lat=%0d err=%0b rdata=0x%08h",
                  t, op, a, wd, lat, err, rd);
      end

      // Final memory image.
      @(negedge clk);
      for (int i = 0; i < WORDS; i++)
         check($sformatf("mem_word%0d", i), dmem[i], ref_word(i));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
